// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access sizes, MMIO offsets, STATUS bits.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  localparam logic [3:0] MMIO_TX_DATA  = 4'h0;
  localparam logic [3:0] MMIO_STATUS   = 4'h4;
  localparam logic [3:0] MMIO_CYCLE_LO = 4'h8;
  localparam logic [3:0] MMIO_CYCLE_HI = 4'hC;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_OVF_BIT   = 2;

  // The unused size encoding is treated as misaligned so it always faults.
  function automatic logic misaligned(mem_size_e size, logic [1:0] addr_lo);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return addr_lo[0];
      MEM_WORD: return addr_lo != 2'b00;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_if.sv
// Data-memory request/response bundle between the core datapath and the responder.
interface mem_if;
  import data_mem_responder_pkg::*;

  logic [31:0] rd_addr;
  mem_size_e   rd_size;
  logic [31:0] rd_data;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  mem_size_e   wr_size;
  logic        wr_enable;

  modport master (
    input  rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
    output rd_data
  );

  modport core (
    output rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
    input  rd_data
  );
endinterface

// File: rtl/data_mem_responder_tx_fifo.sv
// Parameterised synchronous FIFO with extra-MSB pointers; head reads 0 while empty.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = wr_ptr_q == rd_ptr_q;
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A simultaneous pop frees the slot a push into a full FIFO needs.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !reset_i) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: little-endian RAM plus console-TX/cycle-counter MMIO window.
// Optional macro DMEM_CYCLE_COUNTER_EN adds the 64-bit cycle counter (CYCLE_LO/HI read 0 without it).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter logic [31:0] MEM_BASE       = 32'h0001_0000,
  parameter int unsigned MEM_SIZE_BYTES = 65536,
  parameter logic [31:0] MMIO_BASE      = 32'hF000_0000,
  parameter int unsigned TX_FIFO_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  mem_if.master      memif,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       fault_o
);
  localparam int AW        = $clog2(MEM_SIZE_BYTES);
  localparam int RAM_WORDS = MEM_SIZE_BYTES / 4;

  logic [31:0] ram_q [RAM_WORDS];
  logic        fault_q, fault_d, ovf_q, ovf_d;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [31:0] cycle_lo, cycle_hi, status_w;
  logic [31:0] rd_off, rd_word, rd_shift, wr_off, wr_lane_data;
  logic        rd_in_ram, rd_in_mmio, wr_in_ram, wr_in_mmio;
  logic        rd_bad, wr_bad, ram_we, ovf_clr;
  logic [3:0]  wr_be;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [63:0] cycle_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cycle_q <= '0;
    else         cycle_q <= cycle_q + 64'd1;
  end
  assign cycle_lo = cycle_q[31:0];
  assign cycle_hi = cycle_q[63:32];
`else
  assign cycle_lo = '0;
  assign cycle_hi = '0;
`endif

  always_comb begin
    status_w                   = '0;
    status_w[STATUS_FULL_BIT]  = fifo_full;
    status_w[STATUS_EMPTY_BIT] = fifo_empty;
    status_w[STATUS_OVF_BIT]   = ovf_q;
  end

  // Read path: combinational, RAM array holds pre-write data within the cycle.
  always_comb begin
    rd_off       = memif.rd_addr - MEM_BASE;
    rd_in_ram    = rd_off < 32'(MEM_SIZE_BYTES);
    rd_in_mmio   = memif.rd_addr[31:4] == MMIO_BASE[31:4];
    rd_word      = ram_q[rd_off[AW-1:2]];
    rd_shift     = rd_word >> {rd_off[1:0], 3'b000};
    memif.rd_data = '0;
    rd_bad       = 1'b0;
    if (rd_in_ram) begin
      if (misaligned(memif.rd_size, rd_off[1:0])) rd_bad = 1'b1;
      else begin
        case (memif.rd_size)
          MEM_BYTE: memif.rd_data = {24'b0, rd_shift[7:0]};
          MEM_HALF: memif.rd_data = {16'b0, rd_shift[15:0]};
          default:  memif.rd_data = rd_shift;
        endcase
      end
    end else if (rd_in_mmio) begin
      if (memif.rd_size != MEM_WORD || memif.rd_addr[1:0] != 2'b00) rd_bad = 1'b1;
      else begin
        case (memif.rd_addr[3:0])
          MMIO_STATUS:   memif.rd_data = status_w;
          MMIO_CYCLE_LO: memif.rd_data = cycle_lo;
          MMIO_CYCLE_HI: memif.rd_data = cycle_hi;
          default:       memif.rd_data = '0;
        endcase
      end
    end else begin
      rd_bad = 1'b1;
    end
  end

  always_comb begin
    wr_off       = memif.wr_addr - MEM_BASE;
    wr_in_ram    = wr_off < 32'(MEM_SIZE_BYTES);
    wr_in_mmio   = memif.wr_addr[31:4] == MMIO_BASE[31:4];
    ram_we       = 1'b0;
    fifo_push    = 1'b0;
    ovf_clr      = 1'b0;
    wr_bad       = 1'b0;
    case (memif.wr_size)
      MEM_BYTE: begin
        wr_be        = 4'b0001 << wr_off[1:0];
        wr_lane_data = {4{memif.wr_data[7:0]}};
      end
      MEM_HALF: begin
        wr_be        = wr_off[1] ? 4'b1100 : 4'b0011;
        wr_lane_data = {2{memif.wr_data[15:0]}};
      end
      default: begin
        wr_be        = 4'b1111;
        wr_lane_data = memif.wr_data;
      end
    endcase
    if (memif.wr_enable) begin
      if (wr_in_ram) begin
        if (misaligned(memif.wr_size, wr_off[1:0])) wr_bad = 1'b1;
        else                                         ram_we = 1'b1;
      end else if (wr_in_mmio) begin
        if (memif.wr_size != MEM_WORD || memif.wr_addr[1:0] != 2'b00) wr_bad = 1'b1;
        else begin
          case (memif.wr_addr[3:0])
            MMIO_TX_DATA: fifo_push = 1'b1;
            MMIO_STATUS:  ovf_clr   = memif.wr_data[STATUS_OVF_BIT];
            default:      ;
          endcase
        end
      end else begin
        wr_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (ram_we && !reset_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) ram_q[wr_off[AW-1:2]][8*b +: 8] <= wr_lane_data[8*b +: 8];
      end
    end
  end

  assign tx_valid_o = !fifo_empty;
  assign fifo_pop   = tx_valid_o && tx_ready_i;

  tx_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .data_i  (memif.wr_data[7:0]),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (tx_data_o)
  );

  always_comb begin
    fault_d = fault_q || rd_bad || wr_bad;
    ovf_d   = ovf_q;
    if (ovf_clr)                                   ovf_d = 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fault_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      fault_q <= fault_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fault_o = fault_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM vector table plus hand-written fault/FIFO/counter sequences.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       fault_o;
  int         total = 0;
  int         bad = 0;

  mem_if memif_bus();

  data_mem_responder dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .memif      (memif_bus),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .fault_o    (fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    mem_size_e   wsz;
    logic [31:0] waddr;
    logic [31:0] wdata;
    mem_size_e   rsz;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
    logic        chk;
  } vec_t;

  vec_t vecs[15];

  localparam logic [31:0] TXD = 32'hF000_0000;
  localparam logic [31:0] STS = 32'hF000_0004;
  localparam logic [31:0] CLO = 32'hF000_0008;
  localparam logic [31:0] CHI = 32'hF000_000C;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    memif_bus.rd_addr   = 32'h0001_0000;
    memif_bus.rd_size   = MEM_WORD;
    memif_bus.wr_enable = 1'b0;
    memif_bus.wr_addr   = 32'h0001_0000;
    memif_bus.wr_size   = MEM_WORD;
    memif_bus.wr_data   = 32'h0;
  endtask

  task automatic do_reset();
    park();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
  endtask

  task automatic rd(input mem_size_e sz, input logic [31:0] addr, output logic [31:0] data);
    memif_bus.rd_size = sz;
    memif_bus.rd_addr = addr;
    #1;
    data = memif_bus.rd_data;
    memif_bus.rd_addr = 32'h0001_0000;
    memif_bus.rd_size = MEM_WORD;
  endtask

  task automatic wr(input mem_size_e sz, input logic [31:0] addr, input logic [31:0] data);
    memif_bus.wr_enable = 1'b1;
    memif_bus.wr_size   = sz;
    memif_bus.wr_addr   = addr;
    memif_bus.wr_data   = data;
    step();
    memif_bus.wr_enable = 1'b0;
  endtask

  task automatic drain(input string name, input logic [7:0] exp0, input logic [7:0] exp1,
                       input logic [7:0] exp2, input logic [7:0] exp3);
    logic [7:0] got[$];
    logic [7:0] exp[4];
    exp = '{exp0, exp1, exp2, exp3};
    tx_ready_i = 1'b1;
    for (int c = 0; c < 12 && tx_valid_o; c++) begin
      got.push_back(tx_data_o);
      step();
    end
    tx_ready_i = 1'b0;
    check({name, " count"}, 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) check($sformatf("%s byte%0d", name, i), {24'b0, got[i]}, {24'b0, exp[i]});
    end
  endtask

  initial begin
    logic [31:0] d;

    vecs[0]  = '{1'b1, MEM_WORD, 32'h0001_0000, 32'hDEAD_BEEF, MEM_WORD, 32'h0001_0004, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, MEM_WORD, 32'h0001_0000, 32'h0,         MEM_BYTE, 32'h0001_0001, 32'h0000_00BE, 1'b1};
    vecs[2]  = '{1'b0, MEM_WORD, 32'h0001_0000, 32'h0,         MEM_HALF, 32'h0001_0002, 32'h0000_DEAD, 1'b1};
    vecs[3]  = '{1'b1, MEM_BYTE, 32'h0001_0003, 32'h0000_005A, MEM_WORD, 32'h0001_0000, 32'hDEAD_BEEF, 1'b1};
    vecs[4]  = '{1'b0, MEM_WORD, 32'h0001_0000, 32'h0,         MEM_WORD, 32'h0001_0000, 32'h5AAD_BEEF, 1'b1};
    vecs[5]  = '{1'b1, MEM_WORD, 32'h0001_0004, 32'h1122_3344, MEM_BYTE, 32'h0001_0000, 32'h0000_00EF, 1'b1};
    vecs[6]  = '{1'b1, MEM_HALF, 32'h0001_0006, 32'hABCD_9876, MEM_HALF, 32'h0001_0000, 32'h0000_BEEF, 1'b1};
    vecs[7]  = '{1'b0, MEM_WORD, 32'h0001_0000, 32'h0,         MEM_WORD, 32'h0001_0004, 32'h9876_3344, 1'b1};
    vecs[8]  = '{1'b1, MEM_BYTE, 32'h0001_0005, 32'hFFFF_FF00, MEM_BYTE, 32'h0001_0007, 32'h0000_0098, 1'b1};
    vecs[9]  = '{1'b0, MEM_WORD, 32'h0001_0000, 32'h0,         MEM_WORD, 32'h0001_0004, 32'h9876_0044, 1'b1};
    vecs[10] = '{1'b0, MEM_WORD, 32'h0001_0000, 32'h0,         MEM_HALF, 32'h0001_0006, 32'h0000_9876, 1'b1};
    vecs[11] = '{1'b1, MEM_WORD, 32'h0001_FFFC, 32'hCAFE_F00D, MEM_WORD, 32'h0001_0000, 32'h5AAD_BEEF, 1'b1};
    vecs[12] = '{1'b0, MEM_WORD, 32'h0001_0000, 32'h0,         MEM_WORD, 32'h0001_FFFC, 32'hCAFE_F00D, 1'b1};
    vecs[13] = '{1'b0, MEM_WORD, 32'h0001_0000, 32'h0,         MEM_WORD, STS,           32'h0000_0002, 1'b1};
    vecs[14] = '{1'b0, MEM_WORD, 32'h0001_0000, 32'h0,         MEM_WORD, TXD,           32'h0000_0000, 1'b1};

    tx_ready_i = 1'b0;
    do_reset();
    check("rst tx_valid", {31'b0, tx_valid_o}, 32'd0);
    check("rst tx_data", {24'b0, tx_data_o}, 32'd0);
    check("rst fault", {31'b0, fault_o}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      memif_bus.wr_enable = vecs[i].we;
      memif_bus.wr_size   = vecs[i].wsz;
      memif_bus.wr_addr   = vecs[i].waddr;
      memif_bus.wr_data   = vecs[i].wdata;
      memif_bus.rd_size   = vecs[i].rsz;
      memif_bus.rd_addr   = vecs[i].raddr;
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d rd", i), memif_bus.rd_data, vecs[i].exp_rd);
      step();
      park();
    end
    check("vec no fault", {31'b0, fault_o}, 32'd0);

    // Misaligned read: zero data, fault from next cycle.
    memif_bus.rd_size = MEM_WORD;
    memif_bus.rd_addr = 32'h0001_0002;
    #1;
    check("misalign rd data", memif_bus.rd_data, 32'd0);
    check("misalign rd fault same cycle", {31'b0, fault_o}, 32'd0);
    step();
    park();
    check("misalign rd fault", {31'b0, fault_o}, 32'd1);
    wr(MEM_WORD, 32'h0000_0000, 32'h1234_5678);
    wr(MEM_HALF, 32'h0001_0001, 32'h0000_FFFF);
    rd(MEM_WORD, 32'h0001_0000, d);
    check("suppressed writes", d, 32'h5AAD_BEEF);
    check("fault sticky", {31'b0, fault_o}, 32'd1);

    do_reset();
    check("fault cleared", {31'b0, fault_o}, 32'd0);
    rd(MEM_WORD, 32'h0001_0000, d);
    check("ram kept over reset", d, 32'h5AAD_BEEF);
    wr(MEM_WORD, CLO, 32'hFFFF_FFFF);
    wr(MEM_WORD, CHI, 32'hFFFF_FFFF);
    check("cycle write no fault", {31'b0, fault_o}, 32'd0);
    rd(MEM_WORD, 32'h0002_0000, d);
    check("unmapped rd data", d, 32'd0);
    memif_bus.rd_addr = 32'h0002_0000;
    step();
    park();
    check("unmapped rd fault", {31'b0, fault_o}, 32'd1);

    do_reset();
    memif_bus.rd_size = MEM_BYTE;
    memif_bus.rd_addr = STS;
    step();
    park();
    check("mmio byte rd fault", {31'b0, fault_o}, 32'd1);

    // FIFO overflow and drain.
    do_reset();
    memif_bus.wr_enable = 1'b1;
    memif_bus.wr_addr   = TXD;
    memif_bus.wr_data   = 32'h41;
    #1;
    check("push empty valid same cycle", {31'b0, tx_valid_o}, 32'd0);
    step();
    check("push empty valid next", {31'b0, tx_valid_o}, 32'd1);
    for (int b = 8'h42; b <= 8'h45; b++) wr(MEM_WORD, TXD, 32'(b));
    rd(MEM_WORD, STS, d);
    check("status full+ovf", d, 32'b101);
    check("head held", {24'b0, tx_data_o}, 32'h41);
    drain("drain1", 8'h41, 8'h42, 8'h43, 8'h44);
    rd(MEM_WORD, STS, d);
    check("status empty+ovf", d, 32'b110);
    wr(MEM_WORD, STS, 32'h4);
    rd(MEM_WORD, STS, d);
    check("status ovf cleared", d, 32'b010);
    check("fifo no fault", {31'b0, fault_o}, 32'd0);

    // Push while full with a concurrent pop.
    for (int b = 8'h41; b <= 8'h44; b++) wr(MEM_WORD, TXD, 32'(b));
    rd(MEM_WORD, STS, d);
    check("status full", d, 32'b001);
    tx_ready_i = 1'b1;
    wr(MEM_WORD, TXD, 32'h46);
    tx_ready_i = 1'b0;
    rd(MEM_WORD, STS, d);
    check("full push+pop", d, 32'b001);
    drain("drain2", 8'h42, 8'h43, 8'h44, 8'h46);
    rd(MEM_WORD, STS, d);
    check("status after drain2", d, 32'b010);

    // Reset mid-drain; a write held across reset must not land.
    wr(MEM_WORD, TXD, 32'h61);
    wr(MEM_WORD, TXD, 32'h62);
    tx_ready_i = 1'b1;
    step();
    memif_bus.wr_enable = 1'b1;
    memif_bus.wr_size   = MEM_WORD;
    memif_bus.wr_addr   = 32'h0001_0000;
    memif_bus.wr_data   = 32'h0;
    reset_i = 1'b1;
    #1;
    check("reset mid valid", {31'b0, tx_valid_o}, 32'd0);
    check("reset mid data", {24'b0, tx_data_o}, 32'd0);
    step();
    park();
    reset_i = 1'b0;
    tx_ready_i = 1'b0;
    rd(MEM_WORD, 32'h0001_0000, d);
    check("write during reset dropped", d, 32'h5AAD_BEEF);

    do_reset();
    repeat (100) step();
    rd(MEM_WORD, CLO, d);
`ifdef DMEM_CYCLE_COUNTER_EN
    total++;
    if (d < 32'd99 || d > 32'd101) begin
      bad++;
      $display("FAIL cycle_lo: got %0d want 100+-1", d);
    end
`else
    check("cycle_lo off", d, 32'd0);
`endif
    rd(MEM_WORD, CHI, d);
    check("cycle_hi", d, 32'd0);
    check("cycle no fault", {31'b0, fault_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
